// File: rtl/tx_data_path.sv
// Transmit datapath for the double-buffered I2C transmitter: two shift buffers loaded from the
// parallel word (or buffer 0 passed into buffer 1), shifted MSB-first under external control.
module tx_data_path #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             StartTX,
  input  logic [WIDTH-1:0] TXIn,
  input  logic             LoadTXBuff0,
  input  logic             LoadTXBuff1,
  input  logic             ShiftTXBuff0,
  input  logic             ShiftTXBuff1,
  input  logic             passTXbuff,
  output logic [WIDTH-1:0] dataIn,
  output logic             TXBuff0,
  output logic             TXBuff1,
  output logic             TXOut
);

  logic [WIDTH-1:0] buf0_q, buf0_d;
  logic [WIDTH-1:0] buf1_q, buf1_d;

  // Load has priority over shift on the same buffer.
  always_comb begin
    buf0_d = buf0_q;
    if (LoadTXBuff0) begin
      buf0_d = TXIn;
    end else if (ShiftTXBuff0) begin
      buf0_d = {buf0_q[WIDTH-2:0], 1'b0};
    end
  end

  // Pass-load takes the pre-edge buf0, so a simultaneous buf0 shift does not leak in.
  always_comb begin
    buf1_d = buf1_q;
    if (LoadTXBuff1) begin
      buf1_d = passTXbuff ? buf0_q : TXIn;
    end else if (ShiftTXBuff1) begin
      buf1_d = {buf1_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf0_q <= '0;
      buf1_q <= '0;
    end else begin
      buf0_q <= buf0_d;
      buf1_q <= buf1_d;
    end
  end

  assign TXBuff0 = buf0_q[WIDTH-1];
  assign TXBuff1 = buf1_q[WIDTH-1];
  assign dataIn  = passTXbuff ? buf1_q : buf0_q;
  // Line idles high while transmission is disabled.
  assign TXOut   = StartTX ? (passTXbuff ? buf1_q[WIDTH-1] : buf0_q[WIDTH-1]) : 1'b1;

endmodule

// File: tb/tb_tx_data_path.sv
// Bench for tx_data_path: directed vector table, a few combinational corner sequences, and
// randomized control traffic checked against an arithmetic model of the two buffers.
module tb_tx_data_path;

  logic        clk;
  logic        rst_n;
  logic        StartTX;
  logic [31:0] TXIn;
  logic        LoadTXBuff0;
  logic        LoadTXBuff1;
  logic        ShiftTXBuff0;
  logic        ShiftTXBuff1;
  logic        passTXbuff;
  logic [31:0] dataIn;
  logic        TXBuff0;
  logic        TXBuff1;
  logic        TXOut;

  tx_data_path #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .StartTX      (StartTX),
    .TXIn         (TXIn),
    .LoadTXBuff0  (LoadTXBuff0),
    .LoadTXBuff1  (LoadTXBuff1),
    .ShiftTXBuff0 (ShiftTXBuff0),
    .ShiftTXBuff1 (ShiftTXBuff1),
    .passTXbuff   (passTXbuff),
    .dataIn       (dataIn),
    .TXBuff0      (TXBuff0),
    .TXBuff1      (TXBuff1),
    .TXOut        (TXOut)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total  = 0;
  int passed = 0;

  // Model state: the two buffers as plain unsigned numbers.
  longint unsigned m0 = 0;
  longint unsigned m1 = 0;
  localparam longint unsigned Mod = 64'h1_0000_0000;
  localparam longint unsigned Half = 64'h8000_0000;

  typedef struct {
    string       name;
    int          cycles;
    logic        rst_n, start, ld0, ld1, sh0, sh1, pass;
    logic [31:0] txin;
    logic [31:0] exp_data;
    logic        exp_b0, exp_b1, exp_out;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else passed++;
  endtask

  task automatic drive(input logic r, input logic s, input logic l0, input logic l1,
                       input logic s0, input logic s1, input logic p, input logic [31:0] d);
    rst_n = r; StartTX = s; LoadTXBuff0 = l0; LoadTXBuff1 = l1;
    ShiftTXBuff0 = s0; ShiftTXBuff1 = s1; passTXbuff = p; TXIn = d;
  endtask

  // One clock edge; the model advances from the inputs present before the edge.
  task automatic step();
    longint unsigned n0, n1;
    if (!rst_n) begin
      n0 = 0; n1 = 0;
    end else begin
      n0 = LoadTXBuff0 ? longint'(TXIn) : (ShiftTXBuff0 ? (m0 * 2) % Mod : m0);
      n1 = LoadTXBuff1 ? (passTXbuff ? m0 : longint'(TXIn))
                       : (ShiftTXBuff1 ? (m1 * 2) % Mod : m1);
    end
    @(posedge clk);
    #1;
    m0 = n0;
    m1 = n1;
  endtask

  task automatic check_model(input string tag);
    longint unsigned sel;
    logic exp_out;
    sel = passTXbuff ? m1 : m0;
    exp_out = StartTX ? (sel >= Half) : 1'b1;
    chk({tag, ".dataIn"}, dataIn, sel[31:0]);
    chk({tag, ".TXBuff0"}, {31'b0, TXBuff0}, {31'b0, m0 >= Half});
    chk({tag, ".TXBuff1"}, {31'b0, TXBuff1}, {31'b0, m1 >= Half});
    chk({tag, ".TXOut"}, {31'b0, TXOut}, {31'b0, exp_out});
  endtask

  initial begin
    //          name         cyc rst st l0 l1 s0 s1 ps txin          data          b0 b1 out
    vecs.push_back('{"reset",      2, 0, 0, 1, 1, 1, 1, 1, 32'hFFFF_FFFF, 32'h0,        0, 0, 1});
    vecs.push_back('{"load0",      1, 1, 1, 1, 0, 0, 0, 0, 32'h0000_0043, 32'h43,       0, 0, 0});
    vecs.push_back('{"shift25",   25, 1, 1, 0, 0, 1, 0, 0, 32'h0,         32'h8600_0000, 1, 0, 1});
    vecs.push_back('{"shift26",    1, 1, 1, 0, 0, 1, 0, 0, 32'h0,         32'h0C00_0000, 0, 0, 0});
    vecs.push_back('{"shift32",    6, 1, 1, 0, 0, 1, 0, 0, 32'h0,         32'h0,        0, 0, 0});
    vecs.push_back('{"shift33",    1, 1, 1, 0, 0, 1, 0, 0, 32'h0,         32'h0,        0, 0, 0});
    vecs.push_back('{"reload0",    1, 1, 1, 1, 0, 0, 0, 0, 32'h0000_0043, 32'h43,       0, 0, 0});
    vecs.push_back('{"pass",       1, 1, 1, 0, 1, 0, 0, 1, 32'hDEAD_BEEF, 32'h43,       0, 0, 0});
    vecs.push_back('{"shift1x4",   4, 1, 1, 0, 0, 0, 1, 1, 32'h0,         32'h430,      0, 0, 0});
    vecs.push_back('{"buf0_kept",  1, 1, 1, 0, 0, 0, 0, 0, 32'h0,         32'h43,       0, 0, 0});
    vecs.push_back('{"load1_dir",  1, 1, 1, 0, 1, 0, 0, 0, 32'hA5A5_A5A5, 32'h43,       0, 1, 0});
    vecs.push_back('{"sel1",       1, 1, 1, 0, 0, 0, 0, 1, 32'h0,         32'hA5A5_A5A5, 0, 1, 1});
    vecs.push_back('{"ld_vs_sh",   1, 1, 1, 1, 0, 1, 0, 0, 32'h8000_0001, 32'h8000_0001, 1, 1, 1});
    vecs.push_back('{"sh0_pass1",  1, 1, 1, 0, 1, 1, 0, 1, 32'h0,         32'h8000_0001, 0, 1, 1});
    vecs.push_back('{"view0",      1, 1, 1, 0, 0, 0, 0, 0, 32'h0,         32'h2,        0, 1, 0});
    vecs.push_back('{"rst_mid",    1, 0, 1, 0, 0, 1, 1, 1, 32'h0,         32'h0,        0, 0, 0});
    vecs.push_back('{"idle",       1, 1, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,        0, 0, 1});

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].start, vecs[i].ld0, vecs[i].ld1, vecs[i].sh0, vecs[i].sh1,
            vecs[i].pass, vecs[i].txin);
      for (int c = 0; c < vecs[i].cycles; c++) step();
      chk({vecs[i].name, ".dataIn"}, dataIn, vecs[i].exp_data);
      chk({vecs[i].name, ".TXBuff0"}, {31'b0, TXBuff0}, {31'b0, vecs[i].exp_b0});
      chk({vecs[i].name, ".TXBuff1"}, {31'b0, TXBuff1}, {31'b0, vecs[i].exp_b1});
      chk({vecs[i].name, ".TXOut"}, {31'b0, TXOut}, {31'b0, vecs[i].exp_out});
    end

    // Idle line with buf0 empty: StartTX rising drops TXOut with no clock edge.
    StartTX = 1'b1;
    #1;
    chk("start_comb.TXOut", {31'b0, TXOut}, 32'h0);

    // Combinational select: buf0=0x80000001, buf1=0 after these loads.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0001);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("sel_comb0.dataIn", dataIn, 32'h8000_0001);
    chk("sel_comb0.TXOut", {31'b0, TXOut}, 32'h1);
    passTXbuff = 1'b1;
    #1;
    chk("sel_comb1.dataIn", dataIn, 32'h0);
    chk("sel_comb1.TXOut", {31'b0, TXOut}, 32'h0);
    StartTX = 1'b0;
    #1;
    chk("stop_comb.TXOut", {31'b0, TXOut}, 32'h1);

    // Randomized traffic against the model.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check_model("rand_reset");
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 39) != 0), 1'($urandom), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 2) != 0), 1'($urandom), $urandom);
      step();
      check_model($sformatf("rand%0d", i));
      if ($urandom_range(0, 3) == 0) begin
        passTXbuff = ~passTXbuff;
        StartTX = 1'($urandom);
        #1;
        check_model($sformatf("rand%0d_comb", i));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
